regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-port general-purpose register file for the pipelined KRP core. Successor to the single-write, dual-read REGFILE.
- Data width, depth and zero-register handling are configurable.
- Provides two write ports, three read ports with optional write-to-read bypass, and a per-entry busy scoreboard for hazard detection.
- Sits between the decode stage (reads, scoreboard set) and the writeback stage (writes, scoreboard clear).

Parameters:
- DW, 32: data width in bits.
- AW, 5: address width in bits.
- ENTRY, 32: number of implemented entries, 1 to 2^AW; need not be a power of two.
- ZERO_REG, 1: when 1, entry 0 is hardwired to zero.
- BYPASS, 1: when 1, same-cycle write data is forwarded to the read ports and busy outputs.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous reset, active-high.
- WEN0  input  1  write enable, port 0, active-high.
- WA0  input  AW  write address, port 0.
- DI0  input  DW  write data, port 0.
- WEN1  input  1  write enable, port 1, active-high.
- WA1  input  AW  write address, port 1.
- DI1  input  DW  write data, port 1.
- RA0, RA1, RA2  input  AW each  read addresses.
- DOUT0, DOUT1, DOUT2  output  DW each  read data, combinational.
- SET_EN  input  1  mark the entry at SET_A busy (instruction issued with a destination).
- SET_A  input  AW  scoreboard set address.
- BUSY0, BUSY1, BUSY2  output  1 each  busy status of the entries at RA0/RA1/RA2.
- WCOLL  output  1  sticky flag: both write ports targeted the same valid entry.

Behaviour:
- Reset (asynchronous, RST=1):
  - All entries are 0, all busy bits are 0, WCOLL=0.
  - DOUT0-2 = 0 and BUSY0-2 = 0 while RST is held.
  - Writes and SET_EN are ignored while RST=1.
  - A write coincident with RST assertion is lost.
- Valid address: an address a is valid when a < ENTRY, and, if ZERO_REG=1, a != 0.
- Write:
  - On a rising edge, entry WAx <= DIx when WENx=1 and WAx is valid.
  - Writes to invalid addresses are dropped silently.
- Write collision:
  - If WEN0=WEN1=1 and WA0==WA1 (valid), port 1 wins.
  - WCOLL is set to 1 on that edge and holds until reset.
- Read:
  - Combinational, zero latency.
  - RAk >= ENTRY -> DOUTk = 0.
  - ZERO_REG=1 and RAk=0 -> DOUTk = 0, regardless of bypass.
- Bypass with BYPASS=1. When RAk is valid, DOUTk is chosen in this priority order:
  1. DI1 if WEN1=1 and WA1==RAk.
  2. Otherwise DI0 if WEN0=1 and WA0==RAk.
  3. Otherwise the stored value.
- Bypass with BYPASS=0: DOUTk always returns the stored value, i.e. the pre-edge value during a same-cycle write.
- Scoreboard, per valid entry i:
  - Clear condition: a valid write to i on either port this edge.
  - Set condition: SET_EN=1 and SET_A==i.
  - When both occur on the same edge, set wins (a new producer has issued). busy[i] becomes 1.
  - SET_A invalid (out of range, or 0 with ZERO_REG=1) -> ignored.
  - busy[0] is always 0 when ZERO_REG=1.
- Busy output:
  - BUSYk = busy[RAk]; 0 for an invalid RAk.
  - With BYPASS=1, BUSYk is also forced to 0 when a valid write to RAk is present in the same cycle, since its data is forwarded.
  - A same-cycle SET_EN does not affect BUSYk until after the edge.
- No internal pipeline: every state change is visible the cycle after the edge that caused it.

Test Plan:
- Reset then read: RST pulse, RA0=3, RA1=31, RA2=0 -> DOUT0-2=0, BUSY0-2=0, WCOLL=0.
- Basic write/read: WEN0=1, WA0=5, DI0=32'hDEADBEEF for one edge, then RA1=5 -> DOUT1=32'hDEADBEEF. WA0=0, DI0=32'h1234, then RA0=0 -> DOUT0=0 (ZERO_REG=1).
- Collision and bypass: WEN0=WEN1=1, WA0=WA1=7, DI0=32'h11, DI1=32'h22, RA2=7 in the same cycle:
  - Same cycle: DOUT2=32'h22 (bypass).
  - After edge: DOUT2=32'h22, WCOLL=1.
  - Rerun with BYPASS=0: DOUT2 holds the old value in the write cycle.
- Scoreboard: SET_EN=1, SET_A=9; the next cycle RA0=9 -> BUSY0=1. Then WEN1=1, WA1=9 -> BUSY0=0 in that same cycle (BYPASS=1) and stays 0 after the edge.
- Set/clear race: busy[4]=1, then on one edge SET_EN=1, SET_A=4 and WEN0=1, WA0=4 -> after the edge BUSY for RA=4 is 1 and the entry holds DI0.
- Out-of-range: ENTRY=24, WEN0=1, WA0=30, DI0=32'hFF, SET_A=28 with SET_EN=1 -> reading RA=30 gives DOUT=0, BUSY=0. Assert RST mid-sequence -> all state is 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file for the pipelined KRP core: two write ports, three
// combinational read ports with optional write-to-read bypass, and a busy scoreboard.
module regfile_mp #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int ENTRY    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          WEN0,
  input  logic [AW-1:0] WA0,
  input  logic [DW-1:0] DI0,
  input  logic          WEN1,
  input  logic [AW-1:0] WA1,
  input  logic [DW-1:0] DI1,
  input  logic [AW-1:0] RA0,
  input  logic [AW-1:0] RA1,
  input  logic [AW-1:0] RA2,
  output logic [DW-1:0] DOUT0,
  output logic [DW-1:0] DOUT1,
  output logic [DW-1:0] DOUT2,
  input  logic          SET_EN,
  input  logic [AW-1:0] SET_A,
  output logic          BUSY0,
  output logic          BUSY1,
  output logic          BUSY2,
  output logic          WCOLL
);

  // One extra bit so ENTRY == 2**AW is representable as the exclusive limit.
  localparam logic [AW:0] ENTRY_LIM = (AW+1)'(ENTRY);

  function automatic logic addr_valid(input logic [AW-1:0] a);
    logic in_range;
    in_range = ({1'b0, a} < ENTRY_LIM);
    return in_range && !((ZERO_REG != 0) && (a == '0));
  endfunction

  logic [DW-1:0]    mem_q [ENTRY];
  logic [DW-1:0]    mem_d [ENTRY];
  logic [ENTRY-1:0] busy_q;
  logic [ENTRY-1:0] busy_d;
  logic             wcoll_q;
  logic             wcoll_d;

  logic             w0_ok;
  logic             w1_ok;
  logic             set_ok;
  logic [AW-1:0]    ra [3];
  logic [DW-1:0]    dout [3];
  logic             busy_rd [3];

  assign w0_ok  = WEN0 && addr_valid(WA0);
  assign w1_ok  = WEN1 && addr_valid(WA1);
  assign set_ok = SET_EN && addr_valid(SET_A);

  // Port 1 is applied after port 0 so it wins a collision; a set overrides a
  // same-edge clear because it belongs to a newer producer.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    for (int i = 0; i < ENTRY; i++) begin
      if (w0_ok && (WA0 == AW'(i))) begin
        mem_d[i]  = DI0;
        busy_d[i] = 1'b0;
      end
      if (w1_ok && (WA1 == AW'(i))) begin
        mem_d[i]  = DI1;
        busy_d[i] = 1'b0;
      end
      if (set_ok && (SET_A == AW'(i))) begin
        busy_d[i] = 1'b1;
      end
    end
    wcoll_d = wcoll_q || (w0_ok && w1_ok && (WA0 == WA1));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < ENTRY; i++) begin
        mem_q[i] <= '0;
      end
      busy_q  <= '0;
      wcoll_q <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      busy_q  <= busy_d;
      wcoll_q <= wcoll_d;
    end
  end

  assign ra[0] = RA0;
  assign ra[1] = RA1;
  assign ra[2] = RA2;

  // Outputs are held at zero during reset so bypassed write data cannot leak out.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      dout[k]    = '0;
      busy_rd[k] = 1'b0;
      if (!RST && addr_valid(ra[k])) begin
        for (int i = 0; i < ENTRY; i++) begin
          if (ra[k] == AW'(i)) begin
            dout[k]    = mem_q[i];
            busy_rd[k] = busy_q[i];
          end
        end
        if (BYPASS != 0) begin
          if ((w0_ok && (WA0 == ra[k])) || (w1_ok && (WA1 == ra[k]))) begin
            busy_rd[k] = 1'b0;
          end
          if (w1_ok && (WA1 == ra[k])) begin
            dout[k] = DI1;
          end else if (w0_ok && (WA0 == ra[k])) begin
            dout[k] = DI0;
          end
        end
      end
    end
  end

  assign DOUT0 = dout[0];
  assign DOUT1 = dout[1];
  assign DOUT2 = dout[2];
  assign BUSY0 = busy_rd[0];
  assign BUSY1 = busy_rd[1];
  assign BUSY2 = busy_rd[2];
  assign WCOLL = wcoll_q;

endmodule
